// File: rtl/counter_enable_ctrl_if.sv
// Button inputs and counter-enable outputs of counter_enable_ctrl.
// master drives the buttons; slave is the controller itself.
interface counter_enable_ctrl_if;
    logic       btn_run;
    logic       btn_step;
    logic       enable;
    logic [1:0] mode;
    logic       running;

    modport master (
        output btn_run,
        output btn_step,
        input  enable,
        input  mode,
        input  running
    );

    modport slave (
        input  btn_run,
        input  btn_step,
        output enable,
        output mode,
        output running
    );
endinterface

// File: rtl/counter_enable_ctrl.sv
// Run/step control for counter_4bit_up: synchronizes and debounces two
// buttons, runs an IDLE/RUN/STEP FSM and emits a prescaled count enable.
module counter_enable_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PRESCALE        = 4
) (
    input  logic          clock,
    input  logic          reset,
    counter_enable_ctrl_if.slave bus
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES);
    localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10
    } state_e;

    // bit 0 = run button, bit 1 = step button
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    lvl_q;
    logic [1:0]    lvl_d;
    logic [1:0]    lvl_prev_q;
    logic [DW-1:0] db_cnt_q [2];
    logic [DW-1:0] db_cnt_d [2];
    logic [1:0]    press;
    state_e        state_q;
    state_e        state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    // Two-flop synchronizers and the previous debounced level for edge detect
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            lvl_prev_q <= '0;
        end else begin
            sync1_q    <= {bus.btn_step, bus.btn_run};
            sync2_q    <= sync1_q;
            lvl_prev_q <= lvl_q;
        end
    end

    // Debounce: flip the level once the sample has disagreed long enough
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lvl_d[i]    = lvl_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != lvl_q[i]) begin
                if (db_cnt_q[i] == DB_MAX) begin
                    lvl_d[i] = ~lvl_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Press is a one-cycle pulse on a rising debounced level only
    assign press = lvl_q & ~lvl_prev_q;

    // Mode FSM; a run press wins over a simultaneous step press
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (press[0]) begin
                    state_d = RUN;
                end else if (press[1]) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                if (press[0]) begin
                    state_d = IDLE;
                end
            end
            STEP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Prescaler counts only while staying in RUN, so each entry restarts it
    always_comb begin
        presc_d = '0;
        if (state_q == RUN && state_d == RUN) begin
            presc_d = (presc_q == PS_MAX) ? '0 : presc_q + 1'b1;
        end
    end

    // State, prescaler and debounce registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            lvl_q       <= '0;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            lvl_q       <= lvl_d;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
        end
    end

    assign bus.mode    = state_q;
    assign bus.running = (state_q == RUN);
    assign bus.enable  = (state_q == RUN && presc_q == PS_MAX) ||
                         (state_q == STEP);

endmodule

// File: tb/tb_counter_enable_ctrl.sv
// Bench for counter_enable_ctrl: directed latency/boundary scenarios and
// random button/reset activity against a window-based reference model.
module tb_counter_enable_ctrl;

    localparam int D = 4;
    localparam int P = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    counter_enable_ctrl_if bus ();

    counter_enable_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .PRESCALE(P)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: raw history per edge, window rule for debounce,
    // cycles-in-RUN modulo PRESCALE for the enable.
    bit hist [2][64];
    bit lvl  [2];
    bit pend [2];
    int n_edge;
    int m_mode;
    int run_cyc;

    function automatic bit samp(input int b, input int n);
        return (n >= 3) ? hist[b][(n - 2) % 64] : 1'b0;
    endfunction

    function automatic int exp_en();
        return ((m_mode == 1 && (run_cyc % P) == P - 1) || m_mode == 2)
               ? 1 : 0;
    endfunction

    task automatic model_reset();
        n_edge  = 0;
        m_mode  = 0;
        run_cyc = 0;
        for (int b = 0; b < 2; b++) begin
            lvl[b]  = 1'b0;
            pend[b] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit rose [2];
        bit all_diff;
        n_edge++;
        hist[0][n_edge % 64] = bus.btn_run;
        hist[1][n_edge % 64] = bus.btn_step;
        case (m_mode)
            0: begin
                if (pend[0]) begin
                    m_mode  = 1;
                    run_cyc = 0;
                end else if (pend[1]) begin
                    m_mode = 2;
                end
            end
            1: begin
                if (pend[0]) m_mode = 0;
                else run_cyc++;
            end
            default: m_mode = 0;
        endcase
        for (int b = 0; b < 2; b++) begin
            rose[b] = 1'b0;
            if (n_edge - D >= 1) begin
                all_diff = 1'b1;
                for (int k = 0; k <= D; k++) begin
                    if (samp(b, n_edge - k) == lvl[b]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    lvl[b]  = ~lvl[b];
                    rose[b] = lvl[b];
                end
            end
            pend[b] = rose[b];
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        if (!reset) model_edge();
        @(negedge clock);
        chk("mode", bus.mode, m_mode);
        chk("running", bus.running, (m_mode == 1) ? 1 : 0);
        chk("enable", bus.enable, exp_en());
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    int t_a, t_b, seen, n_en, n_st;
    int e [3];
    int hold_left [2];

    initial begin
        bus.btn_run  = 1'b0;
        bus.btn_step = 1'b0;
        model_reset();
        #1;
        chk("rst_mode", bus.mode, 0);
        chk("rst_enable", bus.enable, 0);
        chk("rst_running", bus.running, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Short glitch: no event
        bus.btn_run = 1'b1;
        cycles(3);
        bus.btn_run = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (bus.mode != 2'b00 || bus.enable) seen++;
        end
        chk("glitch_ignored", seen, 0);

        // Held run press: latency and enable cadence
        bus.btn_run = 1'b1;
        t_a = -1;
        n_en = 0;
        for (int k = 0; k < 3; k++) e[k] = -1;
        for (int i = 0; i < 22; i++) begin
            cycle();
            if (t_a < 0 && bus.mode == 2'b01) t_a = i;
            if (bus.enable && n_en < 3) begin
                e[n_en] = i;
                n_en++;
            end
        end
        chk("run_latency", t_a, 7);
        chk("first_en", e[0], 10);
        chk("second_en", e[1], 14);
        chk("third_en", e[2], 18);

        // Second press stops RUN
        bus.btn_run = 1'b0;
        cycles(10);
        bus.btn_run = 1'b1;
        t_a = -1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (t_a < 0 && bus.mode == 2'b00) t_a = i;
        end
        chk("stop_latency", t_a, 7);
        bus.btn_run = 1'b0;
        cycles(10);

        // Third press restarts RUN timing
        bus.btn_run = 1'b1;
        t_a = -1;
        t_b = -1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (t_a < 0 && bus.mode == 2'b01) t_a = i;
            if (t_b < 0 && bus.enable) t_b = i;
        end
        chk("restart_gap", t_b - t_a, P - 1);

        // Asynchronous reset between edges while in RUN
        @(posedge clock);
        model_edge();
        #2 reset = 1'b1;
        #1;
        chk("async_rst_mode", bus.mode, 0);
        chk("async_rst_enable", bus.enable, 0);
        chk("async_rst_running", bus.running, 0);
        model_reset();
        @(negedge clock);
        bus.btn_run = 1'b0;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (bus.mode != 2'b00 || bus.enable) seen++;
        end
        chk("idle_after_rst", seen, 0);

        // Held step: exactly one STEP cycle and one enable
        bus.btn_step = 1'b1;
        n_en = 0;
        n_st = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (bus.enable) n_en++;
            if (bus.mode == 2'b10) n_st++;
        end
        chk("step_cycles", n_st, 1);
        chk("step_enables", n_en, 1);
        bus.btn_step = 1'b0;
        cycles(10);

        // Simultaneous presses: run wins
        bus.btn_run  = 1'b1;
        bus.btn_step = 1'b1;
        n_st = 0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (bus.mode == 2'b10) n_st++;
            if (bus.mode == 2'b01) seen = 1;
        end
        chk("both_no_step", n_st, 0);
        chk("both_run", seen, 1);
        bus.btn_run  = 1'b0;
        bus.btn_step = 1'b0;
        cycles(10);
        bus.btn_run = 1'b1;
        cycles(12);
        bus.btn_run = 1'b0;
        cycles(10);

        // Random button activity with occasional resets
        hold_left[0] = 0;
        hold_left[1] = 0;
        for (int i = 0; i < 2500; i++) begin
            if (hold_left[0] == 0) begin
                bus.btn_run  = 1'($urandom_range(0, 1));
                hold_left[0] = $urandom_range(1, 14);
            end
            if (hold_left[1] == 0) begin
                bus.btn_step = 1'($urandom_range(0, 1));
                hold_left[1] = $urandom_range(1, 14);
            end
            hold_left[0]--;
            hold_left[1]--;
            if (!reset && $urandom_range(0, 399) == 0) begin
                reset = 1'b1;
                model_reset();
            end else if (reset) begin
                reset = 1'b0;
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/counter_enable_ctrl.md
COUNTER_ENABLE_CTRL -- requirements
Module: counter_enable_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the number of consecutive stable synchronized samples required to accept a button level change (legal range >=1).
REQ-002 Parameter PRESCALE, default 4, SHALL set the run-mode enable period in clock cycles (legal range >=1).
REQ-003 clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 btn_run  input  1  SHALL be the raw, asynchronous run/stop toggle button, active-high.
REQ-006 btn_step  input  1  SHALL be the raw, asynchronous single-step button, active-high.
REQ-007 enable  output  1  SHALL be the count-enable strobe that drives the enable input of counter_4bit_up.
REQ-008 mode  output  2  SHALL carry the FSM state: 00 IDLE, 01 RUN, 10 STEP; 11 SHALL never appear.
REQ-009 running  output  1  SHALL be high exactly when mode == 01.

Function
REQ-010 Each button SHALL pass through its own 2-flop synchronizer before any other use.
REQ-011 Each synchronized button SHALL have an independent debounced level and debounce counter.
REQ-012 Debounce counter behaviour SHALL be:
- Counter increments while the synchronized sample differs from the debounced level.
- Counter clears whenever the sample equals the debounced level.
- On reaching DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
REQ-013 A press event SHALL be a one-cycle internal pulse generated on a 0->1 transition of the debounced level; a release SHALL generate no event.
REQ-014 Press latency: with a button high before rising edge E0 and held, the debounced level SHALL rise at edge E0+DEBOUNCE_CYCLES+2, and the FSM SHALL act on the press at edge E0+DEBOUNCE_CYCLES+3.
REQ-015 Any button pulse or glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no event.
REQ-016 FSM transitions from IDLE SHALL be: run press -> RUN; step press -> STEP; otherwise stay in IDLE.
REQ-017 FSM transitions from RUN SHALL be: run press -> IDLE; a step press SHALL be ignored.
REQ-018 STEP SHALL last exactly one cycle, then the FSM SHALL return to IDLE unconditionally; any press arriving in that cycle SHALL be ignored.
REQ-019 If run and step press events occur in the same cycle, the run press SHALL take priority.
REQ-020 Prescaler behaviour SHALL be:
- Counter range is 0..PRESCALE-1.
- It is held at 0 outside RUN.
- It is 0 in the first RUN cycle, increments each RUN cycle, and wraps from PRESCALE-1 to 0.
REQ-021 enable SHALL be high when (mode == RUN and prescaler == PRESCALE-1) or mode == STEP, and low otherwise; it SHALL be decoded from registers only, with no dependence on raw inputs.
REQ-022 In RUN, the first enable SHALL occur in the PRESCALE-th cycle of RUN and then recur every PRESCALE cycles; with PRESCALE=1, enable SHALL stay high throughout RUN.
REQ-023 On leaving RUN, the prescaler SHALL clear, so that every entry into RUN restarts the REQ-022 timing.
REQ-024 Holding a button SHALL yield exactly one press event; a new event requires a debounced release followed by a debounced press.

Reset
REQ-025 Asserting reset SHALL immediately, without a clock edge, force:
- FSM to IDLE (mode = 00), running = 0, enable = 0.
- Prescaler, debounce counters, debounced levels and synchronizer flops all to 0.
REQ-026 Reset asserted mid-RUN or mid-STEP SHALL abort the operation; no enable pulse SHALL occur while reset is high.
REQ-027 A button held high across reset deassertion SHALL be treated as a fresh press once the REQ-014 latency has elapsed after deassertion.

Verification (DEBOUNCE_CYCLES=4, PRESCALE=4)
REQ-028 btn_run pulsed high for 3 cycles -> mode stays 00 and enable stays 0 for 20 cycles.
REQ-029 btn_run raised before edge E0 and held -> mode = 01 after edge E0+7; enable high only in the cycles following edges E0+10, E0+14, E0+18, ...; counter_4bit_up count advances by 1 per pulse.
REQ-030 btn_step held 30 cycles from IDLE -> mode = 10 for exactly one cycle, enable high for exactly one cycle, count +1; no further pulses until the button is released and pressed again.
REQ-031 btn_run and btn_step raised on the same edge -> mode = 01, never 10.
REQ-032 Second run press while in RUN -> mode = 00 and enable = 0; a third press restarts RUN with the first enable again in the 4th RUN cycle.
REQ-033 reset asserted between clock edges while in RUN -> mode = 00, enable = 0 and running = 0 immediately; all stay there until a new debounced press.
